// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit:
// state encodings, opcode/funct constants, datapath select codes.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_TRAP   = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU  = 2'b00;
   localparam logic [1:0] PCSRC_OUT  = 2'b01;
   localparam logic [1:0] PCSRC_JUMP = 2'b10;

   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

   // What the ALU is asked to do in the current state.
   typedef enum logic [1:0] {
      AC_NONE  = 2'd0,
      AC_ADD   = 2'd1,
      AC_SUB   = 2'd2,
      AC_FUNCT = 2'd3
   } alu_class_t;

   // States that hold the memory port and wait on mem_ready.
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

   // Final states of an instruction; leaving them to FETCH retires it.
   function automatic logic is_retire_state(input state_t s);
      return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RWB) ||
             (s == S_BRANCH) || (s == S_ADDIWB) || (s == S_JUMP);
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU control decoder: maps the state's ALU class and funct to alu_ctrl.
// Ports: alu_class, funct in; alu_ctrl, funct_illegal out.
module alu_decoder
   import mc_pkg::*;
(
   input  alu_class_t  alu_class,
   input  logic [5:0]  funct,
   output logic [2:0]  alu_ctrl,
   output logic        funct_illegal
);

   always_comb begin
      alu_ctrl      = ALU_AND;
      funct_illegal = 1'b0;
      case (alu_class)
         AC_ADD: alu_ctrl = ALU_ADD;
         AC_SUB: alu_ctrl = ALU_SUB;
         AC_FUNCT: begin
            case (funct)
               F_ADD:   alu_ctrl = ALU_ADD;
               F_SUB:   alu_ctrl = ALU_SUB;
               F_AND:   alu_ctrl = ALU_AND;
               F_OR:    alu_ctrl = ALU_OR;
               F_SLT:   alu_ctrl = ALU_SLT;
               default: funct_illegal = 1'b1;
            endcase
         end
         default: alu_ctrl = ALU_AND;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for a multi-cycle MIPS datapath with shared memory port.
// Ports: clk, rst, opcode, funct, zero, mem_ready in; datapath strobes and
// selects, state, retired count and fault code out.
module multicycle_ctrl
   import mc_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter int WAIT_LIMIT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_ctrl,
   output logic [1:0]       pc_source,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] retired,
   output logic [1:0]       fault
);

   localparam int WCW = $clog2(WAIT_LIMIT + 1);

   state_t         cur_state;
   state_t         nxt_state;
   logic [WCW-1:0] wait_cnt;
   logic [1:0]     trap_code;
   logic           mem_timeout;
   alu_class_t     alu_class;
   logic           funct_illegal;

   // zero gates pc_write_cond inside the datapath, not in this FSM.
   logic unused_zero;
   assign unused_zero = zero;

   assign state = cur_state;

   alu_decoder u_alu_dec (
      .alu_class     (alu_class),
      .funct         (funct),
      .alu_ctrl      (alu_ctrl),
      .funct_illegal (funct_illegal)
   );

   // This is the WAIT_LIMIT-th consecutive idle cycle in a memory state.
   assign mem_timeout = is_mem_state(cur_state) && !mem_ready &&
                        (wait_cnt == WCW'(WAIT_LIMIT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state <= S_FETCH;
      end else begin
         cur_state <= nxt_state;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      trap_code = FAULT_NONE;
      case (cur_state)
         S_FETCH: begin
            if (mem_ready) begin
               nxt_state = S_DECODE;
            end else if (mem_timeout) begin
               nxt_state = S_TRAP;
               trap_code = FAULT_TIMEOUT;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: nxt_state = S_MEMADR;
               OP_RTYPE:     nxt_state = S_EXEC;
               OP_BEQ:       nxt_state = S_BRANCH;
               OP_ADDI:      nxt_state = S_ADDIEX;
               OP_J:         nxt_state = S_JUMP;
               default: begin
                  nxt_state = S_TRAP;
                  trap_code = FAULT_ILLEGAL;
               end
            endcase
         end
         S_MEMADR: begin
            nxt_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            if (mem_ready) begin
               nxt_state = S_MEMWB;
            end else if (mem_timeout) begin
               nxt_state = S_TRAP;
               trap_code = FAULT_TIMEOUT;
            end
         end
         S_MEMWR: begin
            if (mem_ready) begin
               nxt_state = S_FETCH;
            end else if (mem_timeout) begin
               nxt_state = S_TRAP;
               trap_code = FAULT_TIMEOUT;
            end
         end
         S_EXEC: begin
            if (funct_illegal) begin
               nxt_state = S_TRAP;
               trap_code = FAULT_ILLEGAL;
            end else begin
               nxt_state = S_RWB;
            end
         end
         S_ADDIEX: nxt_state = S_ADDIWB;
         S_MEMWB, S_RWB, S_BRANCH, S_ADDIWB, S_JUMP: nxt_state = S_FETCH;
         S_TRAP:   nxt_state = S_TRAP;
         default:  nxt_state = S_FETCH;
      endcase
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      pc_source     = PCSRC_ALU;
      alu_class     = AC_NONE;
      case (cur_state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            alu_class = AC_ADD;
            // IR and PC only update when the fetch actually completes.
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = SRCB_IMM_SH;
            alu_class = AC_ADD;
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_class = AC_ADD;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_class = AC_FUNCT;
         end
         S_RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_class     = AC_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_OUT;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_class = AC_ADD;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
         end
         default: alu_class = AC_NONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
         retired  <= '0;
         fault    <= FAULT_NONE;
      end else begin
         if (nxt_state != cur_state || !is_mem_state(cur_state) ||
             mem_ready) begin
            wait_cnt <= '0;
         end else begin
            wait_cnt <= wait_cnt + WCW'(1);
         end
         if (is_retire_state(cur_state) && nxt_state == S_FETCH) begin
            retired <= retired + CNT_W'(1);
         end
         // Only the first fault is recorded; TRAP is never left.
         if (cur_state != S_TRAP && nxt_state == S_TRAP) begin
            fault <= trap_code;
         end
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
// Walks R-type, lw, sw, beq, j, addi, illegal and timeout cases.
module tb_multicycle_ctrl;

   logic        clk;
   logic        rst;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        mem_ready;
   logic        pc_write;
   logic        pc_write_cond;
   logic        i_or_d;
   logic        mem_read;
   logic        mem_write;
   logic        ir_write;
   logic        mem_to_reg;
   logic        reg_dst;
   logic        reg_write;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [2:0]  alu_ctrl;
   logic [1:0]  pc_source;
   logic [3:0]  state;
   logic [31:0] retired;
   logic [1:0]  fault;

   int tests = 0;
   int fails = 0;

   logic [5:0] fn_tab [5];
   logic [2:0] ac_tab [5];

   multicycle_ctrl #(
      .CNT_W      (32),
      .WAIT_LIMIT (15)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .opcode        (opcode),
      .funct         (funct),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_ctrl      (alu_ctrl),
      .pc_source     (pc_source),
      .state         (state),
      .retired       (retired),
      .fault         (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst       = 1'b1;
      mem_ready = 1'b0;
      opcode    = 6'b000000;
      funct     = 6'b000000;
      zero      = 1'b0;
      fn_tab[0] = 6'b100000; ac_tab[0] = 3'b010;
      fn_tab[1] = 6'b100010; ac_tab[1] = 3'b110;
      fn_tab[2] = 6'b100100; ac_tab[2] = 3'b000;
      fn_tab[3] = 6'b100101; ac_tab[3] = 3'b001;
      fn_tab[4] = 6'b101010; ac_tab[4] = 3'b111;

      // Reset state
      tick();
      tick();
      chk("rst_state", 32'(state), 0);
      chk("rst_retired", retired, 0);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_mem_read", 32'(mem_read), 1);
      chk("rst_srcb", 32'(alu_src_b), 1);
      chk("rst_irw_gated", 32'(ir_write), 0);

      // Five R-type instructions
      rst = 1'b0;
      mem_ready = 1'b1;
      #1;
      chk("fetch_irw", 32'(ir_write), 1);
      chk("fetch_pcw", 32'(pc_write), 1);
      for (int i = 0; i < 5; i++) begin
         opcode = 6'b000000;
         funct  = fn_tab[i];
         tick();
         chk("r_dec_state", 32'(state), 1);
         chk("r_dec_srcb", 32'(alu_src_b), 3);
         tick();
         chk("r_exec_state", 32'(state), 6);
         chk("r_exec_alu", 32'(alu_ctrl), 32'(ac_tab[i]));
         tick();
         chk("r_rwb_state", 32'(state), 7);
         chk("r_rwb_strb", 32'({reg_write, reg_dst, mem_to_reg}), 3'b110);
         tick();
         chk("r_fetch_state", 32'(state), 0);
      end
      chk("r_retired", retired, 5);

      // lw with three stalled MEMRD cycles
      do_reset();
      chk("lw_rst_retired", retired, 0);
      opcode = 6'b100011;
      tick();
      tick();
      chk("lw_adr_state", 32'(state), 2);
      chk("lw_adr_sel", 32'({alu_src_a, alu_src_b, alu_ctrl}), 6'b110010);
      tick();
      mem_ready = 1'b0;
      #1;
      chk("lw_rd1_state", 32'(state), 3);
      chk("lw_rd_strb", 32'({mem_read, i_or_d}), 2'b11);
      tick();
      chk("lw_rd2_state", 32'(state), 3);
      tick();
      chk("lw_rd3_state", 32'(state), 3);
      tick();
      chk("lw_rd4_state", 32'(state), 3);
      mem_ready = 1'b1;
      tick();
      chk("lw_wb_state", 32'(state), 4);
      chk("lw_wb_strb", 32'({reg_write, mem_to_reg, reg_dst}), 3'b110);
      tick();
      chk("lw_retired", retired, 1);

      // beq then j
      zero   = 1'b1;
      opcode = 6'b000100;
      tick();
      tick();
      chk("beq_state", 32'(state), 8);
      chk("beq_cond", 32'({pc_write_cond, pc_write}), 2'b10);
      chk("beq_pcsrc", 32'(pc_source), 1);
      chk("beq_alu", 32'(alu_ctrl), 3'b110);
      opcode = 6'b000010;
      tick();
      chk("beq_retired", retired, 2);
      tick();
      tick();
      chk("j_state", 32'(state), 11);
      chk("j_pcw", 32'(pc_write), 1);
      chk("j_pcsrc", 32'(pc_source), 2);
      tick();
      chk("j_fetch", 32'(state), 0);
      chk("j_retired", retired, 3);

      // Illegal opcode, held in TRAP for 10 cycles
      opcode = 6'b111111;
      tick();
      tick();
      chk("ill_state", 32'(state), 15);
      chk("ill_fault", 32'(fault), 1);
      mem_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("ill_strobes", 32'({pc_write, pc_write_cond, mem_read,
             mem_write, ir_write, reg_write, state}), 10'b0000001111);
      end
      chk("ill_fault_held", 32'(fault), 1);
      chk("ill_retired", retired, 3);
      rst = 1'b1;
      tick();
      chk("ill_rst_state", 32'(state), 0);
      chk("ill_rst_fault", 32'(fault), 0);
      chk("ill_rst_retired", retired, 0);
      rst = 1'b0;
      mem_ready = 1'b1;
      #1;

      // addi, sw, then R-type with illegal funct
      opcode = 6'b001000;
      tick();
      tick();
      chk("addi_ex_state", 32'(state), 9);
      chk("addi_ex_sel", 32'({alu_src_a, alu_src_b, alu_ctrl}), 6'b110010);
      tick();
      chk("addi_wb_state", 32'(state), 10);
      chk("addi_wb_strb", 32'({reg_write, reg_dst, mem_to_reg}), 3'b100);
      opcode = 6'b101011;
      tick();
      tick();
      tick();
      tick();
      chk("sw_wr_state", 32'(state), 5);
      chk("sw_wr_strb", 32'({mem_write, i_or_d, mem_read}), 3'b110);
      tick();
      chk("sw_retired", retired, 2);
      opcode = 6'b000000;
      funct  = 6'b000000;
      tick();
      tick();
      chk("badf_exec", 32'(state), 6);
      tick();
      chk("badf_state", 32'(state), 15);
      chk("badf_fault", 32'(fault), 1);
      chk("badf_retired", retired, 2);

      // Fetch timeout after WAIT_LIMIT idle cycles
      mem_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 14; i++) tick();
      chk("to_last_fetch", 32'(state), 0);
      tick();
      chk("to_state", 32'(state), 15);
      chk("to_fault", 32'(fault), 2);

      // mem_ready arriving in the limit cycle wins
      do_reset();
      for (int i = 0; i < 14; i++) tick();
      mem_ready = 1'b1;
      #1;
      chk("lim_irw", 32'(ir_write), 1);
      tick();
      chk("lim_state", 32'(state), 1);
      chk("lim_fault", 32'(fault), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore-style main control FSM plus ALU-control decoder that sequences a multi-cycle MIPS datapath. It supports the instruction subset add, sub, and, or, slt, addi, lw, sw, beq and j. The datapath shares one memory port for instructions and data. The FSM waits on a memory-ready handshake, counts retired instructions, and traps on illegal opcodes or memory timeouts.

Parameters:
CNT_W, 32, width of retired-instruction counter
WAIT_LIMIT, 15, max cycles a memory state waits for mem_ready before fault (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory handshake: access completes in the cycle it is high
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if zero
i_or_d  out  1  0 = PC addresses memory, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  latch instruction register
mem_to_reg  out  1  writeback source: 1 = MDR, 0 = ALUOut
reg_dst  out  1  1 = rd, 0 = rt
reg_write  out  1  register file write
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2
alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
state  out  4  current state, for debug
retired  out  CNT_W  instructions completed since reset
fault  out  2  00 none, 01 illegal opcode, 10 memory timeout

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, TRAP 15.
- Reset: state = FETCH, retired = 0, fault = 00, wait counter = 0. All outputs follow FETCH decode from the first post-reset cycle.
- rst mid-instruction discards the instruction, which is not counted.
- FETCH:
  - Outputs: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_ctrl = add, pc_source = 00.
  - ir_write and pc_write equal mem_ready (gated).
  - Go to DECODE when mem_ready = 1; otherwise stay.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 11, alu_ctrl = add (branch target precompute).
  - Next state by opcode: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; anything else -> TRAP with fault = 01.
- MEMADR: alu_src_a = 1, alu_src_b = 10, add. Go to MEMRD if opcode is lw, else MEMWR.
- MEMRD: mem_read = 1, i_or_d = 1. Go to MEMWB on mem_ready; otherwise stay.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Go to FETCH.
- MEMWR: mem_write = 1, i_or_d = 1. Go to FETCH on mem_ready; otherwise stay.
- EXEC:
  - alu_src_a = 1, alu_src_b = 00.
  - alu_ctrl from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Any other funct -> TRAP with fault = 01. Otherwise go to RWB.
- RWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Go to FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, sub, pc_write_cond = 1, pc_source = 01. Go to FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, add. Go to ADDIWB.
- ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Go to FETCH.
- JUMP: pc_write = 1, pc_source = 10. Go to FETCH.
- TRAP:
  - All write and request strobes are 0; state is held until rst.
  - fault is held; retired is frozen.
  - A fault is never overwritten by a later one.
- Unlisted outputs are 0 in every state.
- Memory wait counter (FETCH, MEMRD, MEMWR only):
  - Counts consecutive cycles in the same state with mem_ready = 0.
  - Cleared on state change.
  - When it reaches WAIT_LIMIT while mem_ready is still 0, the next state is TRAP with fault = 10.
  - mem_ready = 1 in the limit cycle wins: the access completes and no fault is raised.
- Retire: retired increments by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, ADDIWB or JUMP. It wraps modulo 2^CNT_W.
- Latency with mem_ready held at 1: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3 cycles.

Decomposition:
- Shared package mc_pkg holds:
  - state encodings;
  - opcode and funct constants;
  - alu_ctrl encodings;
  - alu_src_b and pc_source select encodings;
  - fault codes.
- One natural sub-module, alu_decoder: combinational mapping of state-class and funct to alu_ctrl plus a funct_illegal flag.
- The FSM, wait counter and retire counter stay in multicycle_ctrl.

Test Plan:
- Reset, then mem_ready = 1 and the sequence add, sub, and, or, slt (opcode 0) -> each takes 4 cycles, RWB has reg_write = 1 and reg_dst = 1, retired = 5 after 20 cycles.
- lw (100011) with mem_ready low for 3 cycles in MEMRD -> state stays 3 for 4 cycles, MEMWB has mem_to_reg = 1 and reg_write = 1, retired = 1 after 8 cycles.
- beq (000100) with zero = 1, then j (000010) -> BRANCH has pc_write_cond = 1, pc_source = 01, alu_ctrl = 110; JUMP has pc_write = 1, pc_source = 10; 3 cycles each.
- opcode 111111 in DECODE -> state = 15, fault = 01, all strobes 0 for 10 cycles; rst pulse returns state = 0, fault = 00, retired = 0.
- R-type with funct 000000 -> TRAP with fault = 01 after EXEC, retired unchanged.
- Memory timeout: FETCH with mem_ready = 0 for WAIT_LIMIT = 15 cycles -> TRAP with fault = 10. A repeat run with mem_ready rising exactly in the limit cycle -> DECODE, no fault.
